// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch/decode front end.
package riscv_pkg;

  // Bubble instruction: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes seen by the decoder/controller
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE,  // first cycle after reset release
    S_REQ,   // request outstanding, waiting for ack
    S_HELD,  // word parked in skid buffer while decode stalls
    S_DROP   // redirected; the outstanding ack must be swallowed
  } fetch_state_t;

  // True for the opcodes the controller implements
  function automatic logic is_known_opcode(input logic [6:0] op);
    return op inside {R_TYPE, I_TYPE, LW, SW, BR, U_TYPE, JAL, JALR};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register. A flush or a cycle with nothing to load
// leaves a NOP bubble; hold freezes the entry while hazard logic stalls decode.
module if_id_reg #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  load,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [INST_WIDTH-1:0] instr_in,
  output logic                  valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] instr
);

  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] instr_q, instr_d;

  // Priority: flush beats hold beats load; otherwise insert a bubble
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d = 1'b0;
    pc_d    = pc_q;
    instr_d = NOP_INSTR;
    if (!flush) begin
      if (hold) begin
        valid_d = valid_q;
        instr_d = instr_q;
      end else if (load) begin
        valid_d = 1'b1;
        pc_d    = pc_in;
        instr_d = instr_in;
      end
    end
  end

  // Register with asynchronous active-low reset to an empty (NOP) slot
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage: PC, instruction-memory req/ack handshake, one-entry skid
// buffer for stalls, and the IF/ID register feeding the opcode decoder.
module fetch_if_id_stage #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ack,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_instr,
  output logic [6:0]            id_opcode
);

  import riscv_pkg::fetch_state_t;
  import riscv_pkg::S_IDLE;
  import riscv_pkg::S_REQ;
  import riscv_pkg::S_HELD;
  import riscv_pkg::S_DROP;

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  req_q, req_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic [INST_WIDTH-1:0] skid_q, skid_d;

  logic                  ifid_load;
  logic [PC_WIDTH-1:0]   ifid_pc;
  logic [INST_WIDTH-1:0] ifid_instr;
  logic [PC_WIDTH-1:0]   redir_pc;
  logic [PC_WIDTH-1:0]   pc_plus4;

  // Targets are word aligned; the low bits of redirect_pc are dropped
  assign redir_pc = redirect_pc & ~PC_WIDTH'(3);
  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Fetch FSM next state: redirect always wins over stall
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if (!redirect && stall) state_d = S_HELD;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_HELD:  if (redirect || !stall) state_d = S_REQ;
      S_DROP:  if (imem_ack) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch FSM outputs: PC update, next request, skid capture and IF/ID load
  always_comb begin
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    skid_d     = skid_q;
    ifid_load  = 1'b0;
    ifid_pc    = addr_q;
    ifid_instr = imem_rdata;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redir_pc;
        req_d  = 1'b1;
        addr_d = pc_d;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d   = redir_pc;
            addr_d = redir_pc;
          end else if (!stall) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
            addr_d    = pc_plus4;
          end else begin
            skid_d = imem_rdata;
            req_d  = 1'b0;
          end
        end else if (redirect) begin
          // Handshake is never aborted: address stays put until the ack
          pc_d = redir_pc;
        end
      end
      S_HELD: begin
        if (redirect) begin
          pc_d   = redir_pc;
          req_d  = 1'b1;
          addr_d = redir_pc;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_pc    = pc_q;
          ifid_instr = skid_q;
          pc_d       = pc_plus4;
          req_d      = 1'b1;
          addr_d     = pc_plus4;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = redir_pc;
        if (imem_ack) addr_d = pc_d;
      end
      default: ;
    endcase
  end

  // PC and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      pc_q   <= pc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  // Skid buffer data
  always_ff @(posedge clk) begin
    // NOTE: no reset on this data-only register; it is only read in S_HELD after being written.
    skid_q <= skid_d;
  end

  if_id_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect),
    .hold    (stall),
    .load    (ifid_load),
    .pc_in   (ifid_pc),
    .instr_in(ifid_instr),
    .valid   (id_valid),
    .pc      (id_pc),
    .instr   (id_instr)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_opcode = id_instr[6:0];

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb_fetch_if_id_stage: directed vector table, async-reset sequence, and a
// randomized run against a transaction-level model of the fetch stage.
module tb_fetch_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_instr;
  logic [6:0]  id_opcode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_if_id_stage dut (
    .clk        (clk),
    .reset      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_opcode  (id_opcode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic rq, input logic [31:0] ad,
                           input logic v, input logic [31:0] p, input logic [31:0] ins);
    logic [31:0] op;
    op = {25'd0, ins[6:0]};
    check({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, rq});
    check({tag, ".imem_addr"}, imem_addr, ad);
    check({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, v});
    check({tag, ".id_pc"},     id_pc, p);
    check({tag, ".id_instr"},  id_instr, ins);
    check({tag, ".id_opcode"}, {25'd0, id_opcode}, op);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic ak, logic [31:0] rdata,
                              logic rq, logic [31:0] ad, logic v, logic [31:0] p, logic [31:0] ins);
    vec_t t;
    t.stall = st; t.redirect = rd; t.rpc = rpc; t.ack = ak; t.rdata = rdata;
    t.req = rq; t.addr = ad; t.valid = v; t.pc = p; t.instr = ins;
    return t;
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic        m_started, m_req, m_discard, m_valid;
  logic [31:0] m_pc, m_addr, m_idpc, m_instr;
  logic [31:0] m_skid[$];

  task automatic model_reset();
    m_started = 0; m_req = 0; m_discard = 0; m_valid = 0;
    m_pc = 0; m_addr = 0; m_idpc = 0; m_instr = NOP;
    m_skid.delete();
  endtask

  task automatic bubble();
    m_valid = 0;
    m_instr = NOP;
  endtask

  task automatic issue(input logic [31:0] a);
    m_req  = 1;
    m_addr = a;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                            input logic ack, input logic [31:0] rdata);
    logic got;
    got = m_req && ack;
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      bubble();
      m_skid.delete();
      if (got || !m_req) begin
        m_discard = 0;
        issue(m_pc);
      end else begin
        m_discard = 1;
      end
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
      if (!st) bubble();
      issue(m_pc);
    end else if (got) begin
      if (m_discard) begin
        m_discard = 0;
        if (!st) bubble();
        issue(m_pc);
      end else if (st) begin
        m_skid.push_back(rdata);
        m_req = 0;
      end else begin
        m_valid = 1; m_idpc = m_addr; m_instr = rdata;
        m_pc = m_pc + 32'd4;
        issue(m_pc);
      end
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        m_valid = 1; m_idpc = m_pc; m_instr = m_skid.pop_front();
        m_pc = m_pc + 32'd4;
        issue(m_pc);
      end
    end else if (!st) begin
      bubble();
    end
  endtask

  // Watchdog: the run is a fixed number of cycles; this only guards against a stuck simulator
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1 check_all("reset", 0, 32'h0, 0, 32'h0, NOP);

    // stall, redir, rpc, ack, rdata  ->  req, addr, valid, id_pc, id_instr
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h0,0,32'h0,NOP));           // idle -> req
    vecs.push_back(mk(0,0,0,1,32'h00500093,             1,32'h4,1,32'h0,32'h00500093));
    vecs.push_back(mk(0,0,0,1,32'h00A00113,             1,32'h8,1,32'h4,32'h00A00113));
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h8,0,32'h4,NOP));           // late ack
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h8,0,32'h4,NOP));
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h8,0,32'h4,NOP));
    vecs.push_back(mk(0,0,0,1,32'h00C00193,             1,32'hC,1,32'h8,32'h00C00193));
    vecs.push_back(mk(1,0,0,1,32'h00D00213,             0,32'hC,1,32'h8,32'h00C00193));  // stall at ack
    vecs.push_back(mk(1,0,0,0,0,                        0,32'hC,1,32'h8,32'h00C00193));
    vecs.push_back(mk(1,0,0,0,0,                        0,32'hC,1,32'h8,32'h00C00193));
    vecs.push_back(mk(1,0,0,0,0,                        0,32'hC,1,32'h8,32'h00C00193));
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h10,1,32'hC,32'h00D00213)); // skid drains
    vecs.push_back(mk(0,1,32'h40,0,0,                   1,32'h10,0,32'hC,NOP));          // redirect, pending
    vecs.push_back(mk(0,0,0,1,32'hDEADBEEF,             1,32'h40,0,32'hC,NOP));          // ack discarded
    vecs.push_back(mk(0,0,0,1,32'h000102B3,             1,32'h44,1,32'h40,32'h000102B3));
    vecs.push_back(mk(1,1,32'h83,1,32'h11111111,        1,32'h80,0,32'h40,NOP));         // redirect+stall
    vecs.push_back(mk(0,0,0,1,32'h0000006F,             1,32'h84,1,32'h80,32'h0000006F));
    vecs.push_back(mk(0,1,32'hFFFFFFFC,1,32'h22222222,  1,32'hFFFFFFFC,0,32'h80,NOP));
    vecs.push_back(mk(0,0,0,1,32'h00000063,             1,32'h0,1,32'hFFFFFFFC,32'h00000063)); // wrap
    vecs.push_back(mk(1,0,0,1,32'h00000037,             0,32'h0,1,32'hFFFFFFFC,32'h00000063));
    vecs.push_back(mk(0,0,0,0,0,                        1,32'h4,1,32'h0,32'h00000037));
    vecs.push_back(mk(1,0,0,1,32'h00002083,             0,32'h4,1,32'h0,32'h00000037));  // held again
    vecs.push_back(mk(1,0,0,0,0,                        0,32'h4,1,32'h0,32'h00000037));

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                   vecs[i].pc, vecs[i].instr);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of S_HELD; an ack during reset is ignored
    stall = 0; redirect = 0; imem_ack = 1; imem_rdata = 32'h0BADF00D;
    #2 rst_n = 0;
    #1 check_all("async_reset", 0, 32'h0, 0, 32'h0, NOP);
    repeat (2) @(posedge clk);
    #1 check_all("reset_ack_ignored", 0, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    imem_ack = 0;
    rst_n = 1;
    @(posedge clk);
    #1 check_all("post_reset_req", 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    imem_ack = 1; imem_rdata = 32'h00500093;
    @(posedge clk);
    #1 check_all("post_reset_fetch", 1, 32'h4, 1, 32'h0, 32'h00500093);

    // Randomized run against the model
    @(negedge clk);
    rst_n = 0; stall = 0; redirect = 0; imem_ack = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      logic st, rd, ak;
      logic [31:0] rpc, rdata;
      st    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 9) == 0);
      rpc   = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      ak    = m_req && ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak; imem_rdata = rdata;
      model_step(st, rd, rpc, ak, rdata);
      @(posedge clk);
      #1 check_all($sformatf("rand%0d", c), m_req, m_addr, m_valid, m_idpc, m_instr);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the opcode decoder/controller.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Captures the returned word with its PC into the IF/ID register and presents id_instr[6:0] as the decoder's Opcode.
- Supports stall from hazard logic and redirect/flush from branch/jal/jalr resolution.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble value (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold IF/ID contents and PC advance.
- redirect  in  1  one-cycle pulse: taken branch/jump, flush.
- redirect_pc  in  PC_WIDTH  new fetch target, valid with redirect.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1 and no ack.
- imem_rdata  in  INST_WIDTH  instruction word, valid with imem_ack.
- imem_ack  in  1  response strobe, 1..N cycles after request.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  PC_WIDTH  PC of id_instr.
- id_instr  out  INST_WIDTH  IF/ID instruction.
- id_opcode  out  7  id_instr[6:0], to the controller.

Behaviour:
- Reset (reset=0, async) values:
  - state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR.
- All outputs are registered except id_opcode, which is combinational from id_instr.
- States:
  - S_IDLE: one cycle after reset release, then S_REQ with imem_req=1, imem_addr=pc.
  - S_REQ: imem_req=1, waiting for ack.
  - S_HELD: word received, IF/ID stalled; imem_req=0, word kept in skid buffer.
  - S_DROP: redirect arrived while a request is outstanding; waiting to discard its ack.
- S_REQ, imem_ack=1:
  - redirect: discard word, pc<=redirect_pc, new request to redirect_pc next cycle.
  - !stall: IF/ID<={1,imem_addr,imem_rdata}, pc<=pc+4, next request at pc+4 (back-to-back allowed, latency 1 cycle ack->id_valid).
  - stall: skid<=imem_rdata, go S_HELD, imem_req<=0.
- S_REQ, no ack, redirect: pc<=redirect_pc, go S_DROP; imem_req and imem_addr stay unchanged (handshake never aborted).
- S_DROP:
  - on ack: discard word, go S_REQ at pc.
  - further redirect: only pc updated.
- S_HELD:
  - !stall: IF/ID<=skid with its PC, pc<=pc+4, go S_REQ.
  - redirect: drop skid, pc<=redirect_pc, go S_REQ.
- Flush:
  - redirect forces id_valid<=0, id_instr<=NOP_INSTR next edge, in every state.
  - Redirect overrides stall.
- stall without redirect: IF/ID and pc unchanged.
- PC arithmetic: pc+4 modulo 2^PC_WIDTH. Wrap from 32'hFFFF_FFFC to 0 is silent. redirect_pc[1:0] is ignored (forced 0).
- Only one request is outstanding at a time.
- Mid-operation reset: everything returns to reset values immediately; an in-flight ack is ignored while reset=0.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR.
  - Opcode constants (R_TYPE, I_TYPE, LW, SW, BR, U_TYPE, JAL, JALR).
  - fetch_state_t enum {S_IDLE,S_REQ,S_HELD,S_DROP}.
- One natural sub-module: if_id_reg, the IF/ID register with load/flush/hold controls. Everything else stays in the top.

Test Plan:
- Reset release, ack every cycle with rdata=0x00500093, 0x00A00113 -> imem_addr 0x0,0x4,0x8; id_instr/id_pc pairs (0x00500093,0x0),(0x00A00113,0x4); id_opcode=0010011.
- Ack 3 cycles late -> imem_addr stays 0x4 and imem_req=1 throughout; id_valid=0 until the cycle after ack.
- stall=1 for 4 cycles coinciding with ack of 0x8 -> IF/ID holds 0x4 entry, imem_req=0, state S_HELD; after stall drops, id_pc=0x8 with correct word.
- redirect to 0x40 with request to 0xC outstanding -> ack of 0xC discarded, id_instr=0x00000013, id_valid=0, next imem_addr=0x40.
- redirect and stall asserted together -> flush wins: id_valid=0; next fetch at redirect_pc.
- Assert reset=0 during S_HELD mid-cycle -> outputs at reset values asynchronously; first request after release at RESET_PC.
